bsg_manycore_host_link_mux: RTL and testbench
=============================================

// Module: bsg_manycore_host_link_mux
//
// PURPOSE
// - Shares the single manycore host IO link among num_host_p host/loader channels.
//   Earlier designs wired one loader to io column 0 and tied off all other io columns.
// - Host->manycore requests are merged round-robin into one registered output.
//   Each host has its own outstanding-request credit limit.
// - Manycore->host returns are steered to the owning host by the destination x field.
// - Sits between the host bridges and the manycore io_link_sif of column 0.
//
// PARAMETERS
// - num_host_p         4   number of host channels (>=1)
// - fwd_width_p     "inv"  request packet width (bits)
// - rev_width_p     "inv"  return packet width (bits)
// - x_cord_width_p  "inv"  x coordinate width
// - rev_x_lsb_p     "inv"  bit offset of destination x in a return packet
// - host_x_base_p      0   x coordinate of host 0; host i owns x = host_x_base_p+i
// - max_credits_p      16  outstanding requests allowed per host (>=1)
// - credit_width_lp  derived: $clog2(max_credits_p+1)
//
// PORTS
// - clk_i            in   1                          clock
// - reset_i          in   1                          reset, synchronous, ACTIVE-LOW
// - host_fwd_v_i     in   [num_host_p]               host request valid
// - host_fwd_data_i  in   [num_host_p][fwd_width_p]  host request packet
// - host_fwd_ready_o out  [num_host_p]               request accepted (v&ready)
// - host_rev_v_o     out  [num_host_p]               return valid to host
// - host_rev_data_o  out  [num_host_p][rev_width_p]  return packet (broadcast)
// - host_rev_ready_i in   [num_host_p]               host can take return
// - mc_fwd_v_o       out  1                          request valid to manycore
// - mc_fwd_data_o    out  fwd_width_p                request packet to manycore
// - mc_fwd_ready_i   in   1                          manycore accepts request
// - mc_rev_v_i       in   1                          return valid from manycore
// - mc_rev_data_i    in   rev_width_p                return packet from manycore
// - mc_rev_ready_o   out  1                          return accepted
// - host_credits_o   out  [num_host_p][credit_width_lp]  remaining credits per host
// - error_o          out  1                          sticky: bad return x or credit overflow
//
// BEHAVIOUR
// - Reset (reset_i==0 at a clk edge) sets:
//   mc_fwd_v_o=0, data register=0, rr pointer=0, error_o=0, all credits=max_credits_p.
//   Reset asserted mid-transfer discards the held request; no partial state survives.
// - Forward path: one-entry output register, 1-cycle latency.
//   - eligible[i] = host_fwd_v_i[i] & (credits[i]!=0).
//   - load_en = ~mc_fwd_v_o | mc_fwd_ready_i (a full register refills in the same cycle it drains).
//   - Grant is round-robin over eligible hosts, starting at rr+1 mod num_host_p.
//   - host_fwd_ready_o[i] = grant[i] & load_en. At most one bit is set per cycle.
//   - On a grant: register the packet, set v, rr<=i, credits[i]--.
//   - If no host is eligible and load_en: mc_fwd_v_o<=0.
//   - mc_fwd_v_o, once set, holds with stable data until mc_fwd_ready_i.
// - Return path: combinational steering, 0 latency.
//   - idx = mc_rev_data_i[rev_x_lsb_p +: x_cord_width_p] - host_x_base_p, unsigned.
//   - idx < num_host_p: host_rev_v_o[idx] = mc_rev_v_i; mc_rev_ready_o = host_rev_ready_i[idx].
//     On the handshake, credits[idx]++.
//   - idx >= num_host_p: mc_rev_ready_o=1, packet dropped, error_o<=1.
//   - host_rev_v_o is 0 for all non-selected hosts.
// - Credit arithmetic:
//   - Decrement and increment for the same host in the same cycle: net 0.
//   - Increment when credits==max_credits_p (without a decrement): saturate, error_o<=1.
//   - Decrement never occurs at 0, because the host is ineligible.
// - error_o clears only on reset.
//
// STRUCTURE
// - Shared package holds: credit_width_lp function, x-field extraction helper,
//   error cause enum (e_bad_x, e_credit_ovf) for benches.
// - One sub-module: bsg_manycore_host_link_credit_ctr.
//   A per-host saturating up/down counter with an overflow flag; instantiate num_host_p times.
// - Round-robin arbiter is built inline; no new library arbiter is added.
//
// TESTING
// - Single host: host 0 sends 3 requests with mc_fwd_ready_i=1.
//   -> mc_fwd_v_o is high on cycles 1-3 with matching data; credits 16->13.
// - Fairness: all 4 hosts stay valid with ready=1.
//   -> grant order 1,2,3,0,1,...; no host is granted twice before the others.
// - Backpressure: mc_fwd_ready_i=0 for 5 cycles.
//   -> mc_fwd_v_o and data stay stable; host_fwd_ready_o=0 throughout; no credit change.
// - Credit exhaustion: max_credits_p=2, host 2 sends 3 requests.
//   -> third stalls; a return with x=base+2 -> credit=1, then the third is issued.
// - Return routing: return with x=base+1 while host 1 ready=0.
//   -> mc_rev_ready_o=0; x=base+7 (num_host_p=4) -> dropped, error_o=1.
// - Mid-operation reset: pull reset_i low while mc_fwd_v_o=1.
//   -> next cycle v=0, credits=max, error_o=0.

Source files
------------

// File: rtl/bsg_manycore_host_link_mux_pkg.sv
// Shared types and helpers for the manycore host link mux and its credit counters.
package bsg_manycore_host_link_mux_pkg;

  typedef enum logic [0:0] {
    e_bad_x      = 1'b0,
    e_credit_ovf = 1'b1
  } host_link_err_e;

  function automatic int credit_width(input int max_credits);
    return $clog2(max_credits + 1);
  endfunction

  // Packets are zero-extended to 64 bits before extraction.
  function automatic logic [31:0] get_x(input logic [63:0] pkt,
                                        input int unsigned lsb,
                                        input int unsigned width);
    logic [63:0] mask;
    mask = (64'(1) << width) - 64'(1);
    return 32'((pkt >> lsb) & mask);
  endfunction

endpackage

// File: rtl/bsg_manycore_host_link_credit_ctr.sv
// Per-host saturating up/down credit counter; flags an increment attempted at the maximum.
module bsg_manycore_host_link_credit_ctr
  import bsg_manycore_host_link_mux_pkg::*;
#(
  parameter int max_credits_p = 16,
  localparam int width_lp = credit_width(max_credits_p)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [width_lp-1:0] count_o,
  output logic                ovf_o
);

  localparam logic [width_lp-1:0] max_lp = width_lp'(max_credits_p);

  logic [width_lp-1:0] count_r;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      count_r <= max_lp;
    end else if (inc_i && !dec_i && (count_r != max_lp)) begin
      count_r <= count_r + 1'b1;
    end else if (dec_i && !inc_i && (count_r != '0)) begin
      count_r <= count_r - 1'b1;
    end
  end

  assign count_o = count_r;
  assign ovf_o   = inc_i & ~dec_i & (count_r == max_lp);

endmodule

// File: rtl/bsg_manycore_host_link_mux.sv
// Shares the manycore host io link among several hosts: round-robin request merge with
// per-host credits, and return steering by destination x coordinate.
module bsg_manycore_host_link_mux
  import bsg_manycore_host_link_mux_pkg::*;
#(
  parameter int num_host_p     = 4,
  parameter int fwd_width_p    = 32,
  parameter int rev_width_p    = 32,
  parameter int x_cord_width_p = 4,
  parameter int rev_x_lsb_p    = 0,
  parameter int host_x_base_p  = 0,
  parameter int max_credits_p  = 16,
  localparam int credit_width_lp = credit_width(max_credits_p)
) (
  input  logic                                        clk_i,
  input  logic                                        reset_i,
  input  logic [num_host_p-1:0]                       host_fwd_v_i,
  input  logic [num_host_p-1:0][fwd_width_p-1:0]      host_fwd_data_i,
  output logic [num_host_p-1:0]                       host_fwd_ready_o,
  output logic [num_host_p-1:0]                       host_rev_v_o,
  output logic [num_host_p-1:0][rev_width_p-1:0]      host_rev_data_o,
  input  logic [num_host_p-1:0]                       host_rev_ready_i,
  output logic                                        mc_fwd_v_o,
  output logic [fwd_width_p-1:0]                      mc_fwd_data_o,
  input  logic                                        mc_fwd_ready_i,
  input  logic                                        mc_rev_v_i,
  input  logic [rev_width_p-1:0]                      mc_rev_data_i,
  output logic                                        mc_rev_ready_o,
  output logic [num_host_p-1:0][credit_width_lp-1:0]  host_credits_o,
  output logic                                        error_o
);

  localparam int rr_width_lp = (num_host_p > 1) ? $clog2(num_host_p) : 1;

  logic                   fwd_v_r;
  logic [fwd_width_p-1:0] fwd_data_r;
  logic [rr_width_lp-1:0] rr_r;
  logic                   error_r;

  logic [num_host_p-1:0]  eligible, grant, inc, ovf;
  logic [rr_width_lp-1:0] gnt_idx, cand;
  logic                   found, load_en;
  int unsigned            j;

  for (genvar i = 0; i < num_host_p; i++) begin : g_credit
    assign eligible[i] = host_fwd_v_i[i] & (host_credits_o[i] != '0);

    bsg_manycore_host_link_credit_ctr #(
      .max_credits_p(max_credits_p)
    ) ctr (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .inc_i  (inc[i]),
      .dec_i  (host_fwd_ready_o[i]),
      .count_o(host_credits_o[i]),
      .ovf_o  (ovf[i])
    );
  end

  assign load_en = ~fwd_v_r | mc_fwd_ready_i;

  // Search starts one past the last winner so the previous grantee has lowest priority.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    cand    = '0;
    for (int unsigned off = 1; off <= num_host_p; off++) begin
      j    = (32'(rr_r) + off) % 32'(num_host_p);
      cand = rr_width_lp'(j);
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        gnt_idx     = cand;
      end
    end
  end

  assign host_fwd_ready_o = grant & {num_host_p{load_en}};

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      fwd_v_r    <= 1'b0;
      fwd_data_r <= '0;
      rr_r       <= '0;
    end else if (load_en) begin
      if (found) begin
        fwd_v_r    <= 1'b1;
        fwd_data_r <= host_fwd_data_i[gnt_idx];
        rr_r       <= gnt_idx;
      end else begin
        fwd_v_r <= 1'b0;
      end
    end
  end

  assign mc_fwd_v_o    = fwd_v_r;
  assign mc_fwd_data_o = fwd_data_r;

  logic [31:0]               x_full;
  logic [x_cord_width_p-1:0] idx;
  logic [rr_width_lp-1:0]    sidx;
  logic                      idx_ok, bad_x;

  assign x_full = get_x(64'(mc_rev_data_i), rev_x_lsb_p, x_cord_width_p);
  assign idx    = x_cord_width_p'(x_full - 32'(host_x_base_p));
  assign idx_ok = (32'(idx) < 32'(num_host_p));
  assign sidx   = rr_width_lp'(idx);

  assign host_rev_data_o = {num_host_p{mc_rev_data_i}};

  always_comb begin
    host_rev_v_o   = '0;
    inc            = '0;
    mc_rev_ready_o = 1'b1;
    bad_x          = 1'b0;
    if (idx_ok) begin
      host_rev_v_o[sidx] = mc_rev_v_i;
      mc_rev_ready_o     = host_rev_ready_i[sidx];
      inc[sidx]          = mc_rev_v_i & host_rev_ready_i[sidx];
    end else begin
      bad_x = mc_rev_v_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      error_r <= 1'b0;
    end else if (bad_x || (|ovf)) begin
      error_r <= 1'b1;
    end
  end

  assign error_o = error_r;

endmodule

// File: tb/tb_bsg_manycore_host_link_mux.sv
// Directed bench for the host link mux: two instances, default credits and a 2-credit limit.
module tb_bsg_manycore_host_link_mux;
  import bsg_manycore_host_link_mux_pkg::*;

  localparam int n_lp   = 4;
  localparam int fw_lp  = 16;
  localparam int rw_lp  = 16;
  localparam int cw1_lp = credit_width(16);
  localparam int cw2_lp = credit_width(2);

  logic clk = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk = ~clk;

  logic [n_lp-1:0]              fwd_v, fwd_rdy, rev_v, rev_rdy;
  logic [n_lp-1:0][fw_lp-1:0]   fwd_data;
  logic [n_lp-1:0][rw_lp-1:0]   rev_data;
  logic                         mc_fwd_v, mc_fwd_ready, mc_rev_v, mc_rev_ready, err;
  logic [fw_lp-1:0]             mc_fwd_data;
  logic [rw_lp-1:0]             mc_rev_data;
  logic [n_lp-1:0][cw1_lp-1:0]  credits;

  logic [n_lp-1:0]              fwd_v2, fwd_rdy2, rev_v2, rev_rdy2;
  logic [n_lp-1:0][fw_lp-1:0]   fwd_data2;
  logic [n_lp-1:0][rw_lp-1:0]   rev_data2;
  logic                         mc_fwd_v2, mc_fwd_ready2, mc_rev_v2, mc_rev_ready2, err2;
  logic [fw_lp-1:0]             mc_fwd_data2;
  logic [rw_lp-1:0]             mc_rev_data2;
  logic [n_lp-1:0][cw2_lp-1:0]  credits2;

  bsg_manycore_host_link_mux #(
    .num_host_p(n_lp), .fwd_width_p(fw_lp), .rev_width_p(rw_lp), .x_cord_width_p(4),
    .rev_x_lsb_p(8), .host_x_base_p(2), .max_credits_p(16)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .host_fwd_v_i(fwd_v), .host_fwd_data_i(fwd_data), .host_fwd_ready_o(fwd_rdy),
    .host_rev_v_o(rev_v), .host_rev_data_o(rev_data), .host_rev_ready_i(rev_rdy),
    .mc_fwd_v_o(mc_fwd_v), .mc_fwd_data_o(mc_fwd_data), .mc_fwd_ready_i(mc_fwd_ready),
    .mc_rev_v_i(mc_rev_v), .mc_rev_data_i(mc_rev_data), .mc_rev_ready_o(mc_rev_ready),
    .host_credits_o(credits), .error_o(err)
  );

  bsg_manycore_host_link_mux #(
    .num_host_p(n_lp), .fwd_width_p(fw_lp), .rev_width_p(rw_lp), .x_cord_width_p(4),
    .rev_x_lsb_p(8), .host_x_base_p(2), .max_credits_p(2)
  ) dut2 (
    .clk_i(clk), .reset_i(reset_i),
    .host_fwd_v_i(fwd_v2), .host_fwd_data_i(fwd_data2), .host_fwd_ready_o(fwd_rdy2),
    .host_rev_v_o(rev_v2), .host_rev_data_o(rev_data2), .host_rev_ready_i(rev_rdy2),
    .mc_fwd_v_o(mc_fwd_v2), .mc_fwd_data_o(mc_fwd_data2), .mc_fwd_ready_i(mc_fwd_ready2),
    .mc_rev_v_i(mc_rev_v2), .mc_rev_data_i(mc_rev_data2), .mc_rev_ready_o(mc_rev_ready2),
    .host_credits_o(credits2), .error_o(err2)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_h;

  initial begin
    fwd_v = '0; fwd_data = '0; rev_rdy = '1; mc_fwd_ready = 1'b1;
    mc_rev_v = 1'b0; mc_rev_data = '0;
    fwd_v2 = '0; fwd_data2 = '0; rev_rdy2 = '1; mc_fwd_ready2 = 1'b1;
    mc_rev_v2 = 1'b0; mc_rev_data2 = '0;
    reset_i = 1'b0;
    tick(); tick();
    reset_i = 1'b1;
    #1;

    check("rst_v", 32'(mc_fwd_v), 32'd0);
    check("rst_data", 32'(mc_fwd_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    for (int i = 0; i < n_lp; i++) check("rst_credit", 32'(credits[i]), 32'd16);
    check("rst_credit2", 32'(credits2[3]), 32'd2);

    // single host, three back-to-back requests
    for (int k = 0; k < 3; k++) begin
      fwd_v[0] = 1'b1; fwd_data[0] = 16'hA001 + 16'(k);
      #1;
      check("single_rdy", 32'(fwd_rdy), 32'h1);
      tick();
      check("single_v", 32'(mc_fwd_v), 32'd1);
      check("single_data", 32'(mc_fwd_data), 32'hA001 + 32'(k));
    end
    fwd_v = '0;
    tick();
    check("single_idle_v", 32'(mc_fwd_v), 32'd0);
    check("single_credit", 32'(credits[0]), 32'd13);

    // fairness with all hosts valid
    for (int i = 0; i < n_lp; i++) fwd_data[i] = 16'h1000 + 16'(i << 8);
    fwd_v = '1;
    for (int k = 0; k < 8; k++) begin
      exp_h = (k + 1) % n_lp;
      #1;
      check("rr_rdy", 32'(fwd_rdy), 32'(1) << exp_h);
      tick();
      check("rr_data", 32'(mc_fwd_data), 32'h1000 + 32'(exp_h << 8));
    end
    check("rr_credit0", 32'(credits[0]), 32'd11);
    check("rr_credit1", 32'(credits[1]), 32'd14);
    check("rr_credit3", 32'(credits[3]), 32'd14);

    // backpressure holds the register
    mc_fwd_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_rdy", 32'(fwd_rdy), 32'd0);
      tick();
      check("bp_v", 32'(mc_fwd_v), 32'd1);
      check("bp_data", 32'(mc_fwd_data), 32'h1000);
    end
    check("bp_credit2", 32'(credits[2]), 32'd14);
    fwd_v = '0; mc_fwd_ready = 1'b1;
    tick();
    check("bp_drain_v", 32'(mc_fwd_v), 32'd0);
    check("bp_credit0", 32'(credits[0]), 32'd11);

    // return routing
    rev_rdy = 4'b1101; mc_rev_v = 1'b1; mc_rev_data = 16'h03AB;
    #1;
    check("rev_v", 32'(rev_v), 32'h2);
    check("rev_ready_blocked", 32'(mc_rev_ready), 32'd0);
    check("rev_data", 32'(rev_data[1]), 32'h03AB);
    tick();
    check("rev_blocked_credit", 32'(credits[1]), 32'd14);
    rev_rdy = '1;
    #1;
    check("rev_ready", 32'(mc_rev_ready), 32'd1);
    tick();
    check("rev_credit", 32'(credits[1]), 32'd15);
    check("rev_err_clean", 32'(err), 32'd0);
    mc_rev_data = 16'h09CD;
    #1;
    check("badx_ready", 32'(mc_rev_ready), 32'd1);
    check("badx_v", 32'(rev_v), 32'd0);
    tick();
    mc_rev_v = 1'b0;
    check("badx_err", 32'(err), 32'd1);
    tick();
    check("err_sticky", 32'(err), 32'd1);

    // reset while a request is held
    mc_fwd_ready = 1'b0; fwd_v[3] = 1'b1; fwd_data[3] = 16'h3CC3;
    tick();
    check("mid_v", 32'(mc_fwd_v), 32'd1);
    check("mid_data", 32'(mc_fwd_data), 32'h3CC3);
    reset_i = 1'b0;
    tick();
    reset_i = 1'b1; fwd_v = '0; mc_fwd_ready = 1'b1;
    check("mid_rst_v", 32'(mc_fwd_v), 32'd0);
    check("mid_rst_data", 32'(mc_fwd_data), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_credit3", 32'(credits[3]), 32'd16);
    check("mid_rst_credit0", 32'(credits[0]), 32'd16);

    // credit exhaustion with two credits
    fwd_v2[2] = 1'b1; fwd_data2[2] = 16'hB001;
    #1;
    check("ex_rdy1", 32'(fwd_rdy2), 32'h4);
    tick();
    check("ex_credit1", 32'(credits2[2]), 32'd1);
    fwd_data2[2] = 16'hB002;
    tick();
    check("ex_data2", 32'(mc_fwd_data2), 32'hB002);
    check("ex_credit0", 32'(credits2[2]), 32'd0);
    fwd_data2[2] = 16'hB003;
    #1;
    check("ex_stall_rdy", 32'(fwd_rdy2), 32'd0);
    mc_rev_v2 = 1'b1; mc_rev_data2 = 16'h0411;
    #1;
    check("ex_rev_v", 32'(rev_v2), 32'h4);
    tick();
    mc_rev_v2 = 1'b0;
    check("ex_stall_v", 32'(mc_fwd_v2), 32'd0);
    check("ex_ret_credit", 32'(credits2[2]), 32'd1);
    #1;
    check("ex_rdy3", 32'(fwd_rdy2), 32'h4);
    tick();
    fwd_v2 = '0;
    check("ex_data3", 32'(mc_fwd_data2), 32'hB003);
    check("ex_credit_last", 32'(credits2[2]), 32'd0);

    // overflow: returns beyond the maximum saturate and flag an error
    mc_rev_v2 = 1'b1; mc_rev_data2 = 16'h0422;
    tick(); tick();
    check("ovf_credit_full", 32'(credits2[2]), 32'd2);
    check("ovf_err_before", 32'(err2), 32'd0);
    tick();
    mc_rev_v2 = 1'b0;
    check("ovf_credit_sat", 32'(credits2[2]), 32'd2);
    check("ovf_err", 32'(err2), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
